// File: rtl/mem_io_bridge_if.sv
// Bus bundle between the LC-3 control side and the SRAM/IO bridge.
interface mem_io_bridge_if;
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Switches;
  logic [15:0] SRAM_Data_in;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;
  logic [19:0] SRAM_ADDR;
  logic        CE_N;
  logic        OE_N;
  logic        WE_N;
  logic        UB_N;
  logic        LB_N;
  logic [15:0] Data_to_SRAM;
  logic        SRAM_Drive;
  logic [15:0] HEX_Out;

  modport master (
    output MIO_EN, R_W, MAR, MDR, Switches, SRAM_Data_in,
    input  Data_to_CPU, Mem_Ready, SRAM_ADDR, CE_N, OE_N,
    input  WE_N, UB_N, LB_N, Data_to_SRAM, SRAM_Drive, HEX_Out
  );

  modport slave (
    input  MIO_EN, R_W, MAR, MDR, Switches, SRAM_Data_in,
    output Data_to_CPU, Mem_Ready, SRAM_ADDR, CE_N, OE_N,
    output WE_N, UB_N, LB_N, Data_to_SRAM, SRAM_Drive, HEX_Out
  );
endinterface

// File: rtl/mem_io_bridge.sv
// Memory/IO sequencer: wait-state SRAM strobes, Mem_Ready pulse,
// switch input and hex display register at the IO address.
module mem_io_bridge #(
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic Clk,
  input  logic Reset,
  mem_io_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        ready;
  logic [15:0] sw_meta, sw_sync;
  logic [15:0] hex;
  logic        is_io;
  logic        sram;
  logic        hex_load;

  assign is_io = (bus.MAR == IO_ADDR);
  assign sram  = bus.MIO_EN & ~is_io & ~Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.MIO_EN) begin
          state_n = S_WAIT;
          cnt_n   = 3'd1;
        end
      end
      S_WAIT: begin
        if (!bus.MIO_EN) begin
          state_n = S_IDLE;
        end else if (cnt == 3'(WAIT_STATES)) begin
          ready   = 1'b1;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end
      S_DONE: begin
        if (!bus.MIO_EN) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One display load per request: only the first wait cycle qualifies.
  assign hex_load = (state == S_WAIT) & (cnt == 3'd1) &
                    bus.MIO_EN & bus.R_W & is_io;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_meta <= 16'h0;
      sw_sync <= 16'h0;
      hex     <= 16'h0;
    end else begin
      sw_meta <= bus.Switches;
      sw_sync <= sw_meta;
      if (hex_load) hex <= bus.MDR;
    end
  end

  assign bus.Mem_Ready    = ready & ~Reset;
  assign bus.SRAM_ADDR    = {4'h0, bus.MAR};
  assign bus.CE_N         = ~sram;
  assign bus.UB_N         = ~sram;
  assign bus.LB_N         = ~sram;
  assign bus.OE_N         = ~(sram & ~bus.R_W);
  // Cycle 0 of a write is address setup; WE_N waits for the WAIT state.
  assign bus.WE_N         = ~(sram & bus.R_W & (state == S_WAIT));
  assign bus.SRAM_Drive   = sram & bus.R_W;
  assign bus.Data_to_SRAM = bus.MDR;
  assign bus.Data_to_CPU  = is_io ? sw_sync : bus.SRAM_Data_in;
  assign bus.HEX_Out      = hex;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a read-data scoreboard.
module tb_mem_io_bridge;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;
  logic [15:0] exp_q[$];

  mem_io_bridge_if bus ();

  mem_io_bridge #(
    .WAIT_STATES(2),
    .IO_ADDR(16'hFFFF)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every Mem_Ready pulse consumes one expected read value.
  always @(negedge Clk) begin
    if (Reset === 1'b0 && bus.Mem_Ready === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_extra_ready", 32'(exp_q.size()), 1);
      else chk("sb_data", 32'(bus.Data_to_CPU), 32'(exp_q.pop_front()));
    end
  end

  task automatic drive(input logic en, input logic rw,
                       input logic [15:0] mar, input logic [15:0] mdr);
    @(posedge Clk);
    #1;
    bus.MIO_EN = en;
    bus.R_W    = rw;
    bus.MAR    = mar;
    bus.MDR    = mdr;
  endtask

  task automatic chk_idle_strobes(input string tag);
    chk({tag, "_ce"}, 32'(bus.CE_N), 1);
    chk({tag, "_oe"}, 32'(bus.OE_N), 1);
    chk({tag, "_we"}, 32'(bus.WE_N), 1);
    chk({tag, "_ub"}, 32'(bus.UB_N), 1);
    chk({tag, "_lb"}, 32'(bus.LB_N), 1);
    chk({tag, "_drv"}, 32'(bus.SRAM_Drive), 0);
    chk({tag, "_rdy"}, 32'(bus.Mem_Ready), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    bus.MIO_EN       = 1'b0;
    bus.R_W          = 1'b0;
    bus.MAR          = 16'h0;
    bus.MDR          = 16'h0;
    bus.Switches     = 16'h0;
    bus.SRAM_Data_in = 16'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_idle_strobes("rst");
    chk("rst_hex", 32'(bus.HEX_Out), 0);
    @(posedge Clk);
    #1 Reset = 1'b0;

    // 1: SRAM read, three cycles
    bus.SRAM_Data_in = 16'h1234;
    exp_q.push_back(16'h1234);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 16'h3000, 16'h0);
      @(negedge Clk);
      chk("rd_oe", 32'(bus.OE_N), 0);
      chk("rd_we", 32'(bus.WE_N), 1);
      chk("rd_ce", 32'(bus.CE_N), 0);
      chk("rd_rdy", 32'(bus.Mem_Ready), (c == 2) ? 1 : 0);
      chk("rd_addr", 32'(bus.SRAM_ADDR), 32'h03000);
    end
    drive(1'b0, 1'b0, 16'h3000, 16'h0);
    @(negedge Clk);
    chk_idle_strobes("rd_end");

    // 2: SRAM write, two cycles then low
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 16'h0040, 16'hBEEF);
      @(negedge Clk);
      chk("wr_we", 32'(bus.WE_N), (c == 1) ? 0 : 1);
      chk("wr_drv", 32'(bus.SRAM_Drive), 1);
      chk("wr_oe", 32'(bus.OE_N), 1);
      chk("wr_data", 32'(bus.Data_to_SRAM), 32'hBEEF);
      chk("wr_rdy", 32'(bus.Mem_Ready), 0);
    end
    drive(1'b0, 1'b1, 16'h0040, 16'hBEEF);
    @(negedge Clk);
    chk_idle_strobes("wr_end");

    // 3: IO write to the hex display
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 16'hFFFF, 16'h00A5);
      @(negedge Clk);
      chk("io_wr_ce", 32'(bus.CE_N), 1);
      chk("io_wr_we", 32'(bus.WE_N), 1);
      chk("io_wr_drv", 32'(bus.SRAM_Drive), 0);
      chk("io_wr_hex_pre", 32'(bus.HEX_Out), 0);
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge Clk);
    chk("io_wr_hex", 32'(bus.HEX_Out), 32'h00A5);

    // 4: IO read of synchronised switches
    bus.Switches = 16'h5A5A;
    repeat (3) drive(1'b0, 1'b0, 16'h0000, 16'h0);
    exp_q.push_back(16'h5A5A);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 16'hFFFF, 16'h0);
      @(negedge Clk);
      chk("io_rd_ce", 32'(bus.CE_N), 1);
      chk("io_rd_oe", 32'(bus.OE_N), 1);
      chk("io_rd_rdy", 32'(bus.Mem_Ready), (c == 2) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0);
    @(negedge Clk);
    chk("io_hex_hold", 32'(bus.HEX_Out), 32'h00A5);

    // 5: long read, one-cycle gap, then a read at 0xFFFE (plain SRAM)
    bus.SRAM_Data_in = 16'hCAFE;
    exp_q.push_back(16'hCAFE);
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 16'h0100, 16'h0);
      @(negedge Clk);
      chk("long_rdy", 32'(bus.Mem_Ready), (c == 2) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 16'h0100, 16'h0);
    @(negedge Clk);
    chk("gap_rdy", 32'(bus.Mem_Ready), 0);
    bus.SRAM_Data_in = 16'h7777;
    exp_q.push_back(16'h7777);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 16'hFFFE, 16'h0);
      @(negedge Clk);
      chk("fffe_ce", 32'(bus.CE_N), 0);
      chk("fffe_rdy", 32'(bus.Mem_Ready), (c == 2) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0);

    // 6: reset in cycle 1 of an IO write
    drive(1'b1, 1'b1, 16'hFFFF, 16'h3C3C);
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    chk_idle_strobes("rst_mid");
    @(posedge Clk);
    #1;
    Reset      = 1'b0;
    bus.MIO_EN = 1'b0;
    @(negedge Clk);
    chk_idle_strobes("post_rst");
    chk("post_rst_hex", 32'(bus.HEX_Out), 0);

    // Fresh read after reset starts from IDLE
    bus.SRAM_Data_in = 16'h0F0F;
    exp_q.push_back(16'h0F0F);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 16'h0200, 16'h0);
      @(negedge Clk);
      chk("after_rst_rdy", 32'(bus.Mem_Ready), (c == 2) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h0);
    repeat (2) @(posedge Clk);
    chk("sb_left", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
